// File: rtl/psum_mem_arbiter.sv
`default_nettype none
// ============================================================================
// psum_mem_arbiter : shares the single-port partial-sum SRAM between the
//                    convolution controller (C, fixed priority) and host readout
//                    (H, starvation-protected).
// Revision         : 1.0
// ============================================================================
module psum_mem_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 32,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              h_req,
  input  logic [ADDR_W-1:0] h_addr,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              h_forced
);

  localparam logic [7:0] C_STARVE_LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    C_PRIO  = 1'b0,
    H_FORCE = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [7:0]        r_wait_cnt;
  logic [7:0]        w_wait_cnt_next;
  logic [RD_LAT-1:0] r_tag_vld;
  logic [RD_LAT-1:0] r_tag_own;   // 1 = host owns the read in this stage
  logic              w_c_gnt;
  logic              w_h_gnt;
  logic              w_h_forced;
  logic              w_rd_gnt;
  logic              w_tail_vld;
  logic              w_tail_own;

  always_comb begin
    w_c_gnt         = 1'b0;
    w_h_gnt         = 1'b0;
    w_h_forced      = 1'b0;
    w_wait_cnt_next = 8'd0;
    w_state_next    = C_PRIO;

    if (!rst_in) begin
      case (r_state)
        H_FORCE: begin
          w_h_gnt    = h_req;
          w_h_forced = h_req;
        end
        default: begin
          w_c_gnt = c_req;
          w_h_gnt = h_req & ~c_req;
        end
      endcase
    end

    // Blocked host cycles accumulate; any host grant or withdrawal restarts the count.
    if (h_req && !w_h_gnt) begin
      if (r_wait_cnt >= C_STARVE_LIMIT) begin
        w_wait_cnt_next = C_STARVE_LIMIT;
      end else begin
        w_wait_cnt_next = r_wait_cnt + 8'd1;
      end
    end

    if ((r_state == C_PRIO) && (w_wait_cnt_next == C_STARVE_LIMIT)) begin
      w_state_next = H_FORCE;
    end
  end

  assign w_rd_gnt = (w_c_gnt & ~c_we) | w_h_gnt;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_state    <= C_PRIO;
      r_wait_cnt <= 8'd0;
      r_tag_vld  <= '0;
      r_tag_own  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_wait_cnt   <= w_wait_cnt_next;
      r_tag_vld[0] <= w_rd_gnt;
      r_tag_own[0] <= w_h_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_own[i] <= r_tag_own[i-1];
      end
    end
  end

  assign w_tail_vld = r_tag_vld[RD_LAT-1];
  assign w_tail_own = r_tag_own[RD_LAT-1];

  assign c_gnt     = w_c_gnt;
  assign h_gnt     = w_h_gnt;
  assign h_forced  = w_h_forced;
  assign mem_en    = w_c_gnt | w_h_gnt;
  assign mem_we    = w_c_gnt & c_we;
  assign mem_addr  = w_c_gnt ? c_addr : (w_h_gnt ? h_addr : '0);
  assign mem_wdata = w_c_gnt ? c_wdata : '0;

  // Responses are steered by the owner tag that travelled with the read.
  assign c_rvalid  = ~rst_in & w_tail_vld & ~w_tail_own;
  assign h_rvalid  = ~rst_in & w_tail_vld & w_tail_own;
  assign c_rdata   = c_rvalid ? mem_rdata : '0;
  assign h_rdata   = h_rvalid ? mem_rdata : '0;

endmodule
`default_nettype wire
